chargen: RTL and testbench

Character-generator source that feeds the output FIFO. Produces the RFC 864 rotating pattern: lines of printable ASCII (0x20..0x7E), each line starting one character later than the previous one, terminated by CR LF. Drives the FIFO's active-low write strobe directly and throttles on the FIFO's active-low full flag. It never overruns the FIFO and never drops or duplicates a byte.

---
 rtl/chargen.sv | 86 ++++++++
 tb/tb_chargen.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/chargen.sv
// Rotating-pattern character generator (RFC 864 chargen) that writes straight into
// a FIFO through its active-low write strobe and stalls on the FIFO's full flag.
module chargen #(
    parameter int unsigned LINE_LEN   = 72,
    parameter int unsigned LINES      = 0,
    parameter logic [7:0]  FIRST_CHAR = 8'h20,
    parameter logic [7:0]  LAST_CHAR  = 8'h7E
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        n_run,
    input  logic        n_full,
    output logic [7:0]  port_out,
    output logic        n_wr,
    output logic        n_done,
    output logic [15:0] line_cnt
);

    typedef enum logic [2:0] {IDLE, CHAR, CR, LF, DONE} state_t;

    localparam logic [6:0]  LAST_COL = 7'(LINE_LEN - 1);
    localparam logic [15:0] LINES_16 = 16'(LINES);

    state_t     state;
    logic [7:0] cur;
    logic [7:0] start;
    logic [6:0] col;
    logic       wr;

    function automatic logic [7:0] wrap_inc(input logic [7:0] c);
        return (c == LAST_CHAR) ? FIRST_CHAR : c + 8'd1;
    endfunction

    // The strobe follows n_run/n_full in the same cycle so a full FIFO is never written.
    assign wr   = ((state == CHAR) || (state == CR) || (state == LF)) && !n_run && n_full;
    assign n_wr = ~wr;

    always_comb begin
        // NOTE: port_out gets a value before the case so every path assigns it and no latch is inferred.
        port_out = cur;
        case (state)
            CR:      port_out = 8'h0D;
            LF:      port_out = 8'h0A;
            default: port_out = cur;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cur      <= FIRST_CHAR;
            start    <= FIRST_CHAR;
            col      <= '0;
            line_cnt <= '0;
            n_done   <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments, so every branch below reads pre-edge register values.
            case (state)
                IDLE: if (!n_run) state <= CHAR;
                CHAR: if (wr) begin
                    cur <= wrap_inc(cur);
                    if (col == LAST_COL) begin
                        col   <= '0;
                        state <= CR;
                    end else begin
                        col <= col + 7'd1;
                    end
                end
                CR: if (wr) state <= LF;
                LF: if (wr) begin
                    line_cnt <= line_cnt + 16'd1;
                    start    <= wrap_inc(start);
                    cur      <= wrap_inc(start);
                    if ((LINES_16 != 16'd0) && (line_cnt + 16'd1 == LINES_16)) begin
                        state  <= DONE;
                        n_done <= 1'b0;
                    end else begin
                        state <= CHAR;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_chargen.sv
// Directed bench for chargen: default-geometry instance plus a LINE_LEN=4, LINES=2 instance.
module tb_chargen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        n_run = 1'b1;
    logic        n_full = 1'b1;
    logic [7:0]  port_out, port_out_b;
    logic        n_wr, n_wr_b;
    logic        n_done, n_done_b;
    logic [15:0] line_cnt, line_cnt_b;

    int n_cmp = 0;
    int n_bad = 0;

    chargen dut (
        .clk(clk), .rst(rst), .n_run(n_run), .n_full(n_full),
        .port_out(port_out), .n_wr(n_wr), .n_done(n_done), .line_cnt(line_cnt)
    );

    chargen #(.LINE_LEN(4), .LINES(2)) dut_b (
        .clk(clk), .rst(rst), .n_run(n_run), .n_full(n_full),
        .port_out(port_out_b), .n_wr(n_wr_b), .n_done(n_done_b), .line_cnt(line_cnt_b)
    );

    always #5 clk = ~clk;

    // Reference stream: byte i of a line of len printable chars plus CR LF.
    function automatic logic [7:0] exp_byte(input int i, input int len);
        int line;
        int pos;
        line = i / (len + 2);
        pos  = i % (len + 2);
        if (pos == len) return 8'h0D;
        if (pos == len + 1) return 8'h0A;
        return 8'(32 + (line + pos) % 95);
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; n_run = 1'b1; n_full = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Inputs change on the falling edge; outputs are settled 1 time unit later.
    task automatic set_inputs(input logic run, input logic full);
        @(negedge clk);
        n_run = run; n_full = full;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk); rst = 1'b1; #1;
        n_cmp++; if (n_wr !== 1'b1)      begin n_bad++; $display("FAIL reset_n_wr got %b want 1", n_wr); end
        n_cmp++; if (port_out !== 8'h20) begin n_bad++; $display("FAIL reset_port_out got %h want 20", port_out); end
        n_cmp++; if (line_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_line_cnt got %0d want 0", line_cnt); end
        n_cmp++; if (n_done !== 1'b1)    begin n_bad++; $display("FAIL reset_n_done got %b want 1", n_done); end
        apply_reset();
        repeat (3) begin
            set_inputs(1'b1, 1'b1);
            n_cmp++; if (n_wr !== 1'b1) begin n_bad++; $display("FAIL idle_n_wr got %b want 1", n_wr); end
        end
    endtask

    task automatic test_first_line();
        logic [7:0] cap[$];
        apply_reset();
        set_inputs(1'b0, 1'b1);
        n_cmp++; if (n_wr !== 1'b1) begin n_bad++; $display("FAIL idle_no_write got %b want 1", n_wr); end
        for (int c = 0; c < 200 && cap.size() < 74; c++) begin
            set_inputs(1'b0, 1'b1);
            if (c == 0) begin
                n_cmp++; if (n_wr !== 1'b0) begin n_bad++; $display("FAIL first_strobe got %b want 0", n_wr); end
            end
            if (n_wr === 1'b0) cap.push_back(port_out);
        end
        n_cmp++; if (cap.size() != 74) begin n_bad++; $display("FAIL first_line_count got %0d want 74", cap.size()); end
        foreach (cap[i]) begin
            n_cmp++;
            if (cap[i] !== exp_byte(i, 72)) begin n_bad++; $display("FAIL first_line_byte[%0d] got %h want %h", i, cap[i], exp_byte(i, 72)); end
        end
        set_inputs(1'b1, 1'b1);
        n_cmp++; if (line_cnt !== 16'd1) begin n_bad++; $display("FAIL first_line_cnt got %0d want 1", line_cnt); end
        set_inputs(1'b0, 1'b1);
        n_cmp++; if (n_wr !== 1'b0 || port_out !== 8'h21) begin n_bad++; $display("FAIL byte75 got n_wr=%b %h want 0 21", n_wr, port_out); end
    endtask

    task automatic test_rotation();
        logic [7:0] cap[$];
        int nb;
        nb = 96 * 74;
        apply_reset();
        for (int c = 0; c < nb + 50 && cap.size() < nb; c++) begin
            set_inputs(1'b0, 1'b1);
            if (n_wr === 1'b0) cap.push_back(port_out);
        end
        set_inputs(1'b1, 1'b1);
        n_cmp++; if (cap.size() != nb) begin n_bad++; $display("FAIL rot_count got %0d want %0d", cap.size(), nb); end
        n_cmp++; if (line_cnt !== 16'd96) begin n_bad++; $display("FAIL rot_line_cnt got %0d want 96", line_cnt); end
        if (cap.size() == nb) begin
            n_cmp++; if (cap[94*74] !== 8'h7E)   begin n_bad++; $display("FAIL rot_l94_c0 got %h want 7e", cap[94*74]); end
            n_cmp++; if (cap[94*74+1] !== 8'h20) begin n_bad++; $display("FAIL rot_l94_c1 got %h want 20", cap[94*74+1]); end
            n_cmp++; if (cap[95*74] !== 8'h20)   begin n_bad++; $display("FAIL rot_l95_c0 got %h want 20", cap[95*74]); end
            foreach (cap[i]) begin
                if (cap[i] !== exp_byte(i, 72)) begin
                    n_cmp++; n_bad++;
                    $display("FAIL rot_byte[%0d] got %h want %h", i, cap[i], exp_byte(i, 72));
                end
            end
            n_cmp++;
        end
    endtask

    task automatic test_back_pressure();
        logic [7:0] cap[$];
        logic full;
        apply_reset();
        for (int c = 0; c < 160; c++) begin
            full = !((c >= 10 && c <= 14) || c == 40 || c == 80);
            set_inputs(1'b0, full);
            if (c > 0) begin
                n_cmp++;
                if (n_wr !== !full) begin n_bad++; $display("FAIL bp_n_wr[cycle %0d] got %b want %b", c, n_wr, !full); end
            end
            if (c == 80) begin
                n_cmp++; if (port_out !== 8'h0A) begin n_bad++; $display("FAIL bp_cr_lf_hold got %h want 0a", port_out); end
            end
            if (n_wr === 1'b0) cap.push_back(port_out);
        end
        n_cmp++; if (cap.size() != 152) begin n_bad++; $display("FAIL bp_count got %0d want 152", cap.size()); end
        foreach (cap[i]) begin
            n_cmp++;
            if (cap[i] !== exp_byte(i, 72)) begin n_bad++; $display("FAIL bp_byte[%0d] got %h want %h", i, cap[i], exp_byte(i, 72)); end
        end
    endtask

    task automatic test_pause();
        logic [7:0] cap[$];
        logic run;
        apply_reset();
        for (int c = 0; c < 60; c++) begin
            run = (c >= 20 && c <= 22);
            set_inputs(run, 1'b1);
            if (run) begin
                n_cmp++; if (n_wr !== 1'b1)     begin n_bad++; $display("FAIL pause_n_wr[cycle %0d] got %b want 1", c, n_wr); end
                n_cmp++; if (port_out !== 8'h33) begin n_bad++; $display("FAIL pause_hold[cycle %0d] got %h want 33", c, port_out); end
            end
            if (n_wr === 1'b0) cap.push_back(port_out);
        end
        n_cmp++; if (cap.size() != 56) begin n_bad++; $display("FAIL pause_count got %0d want 56", cap.size()); end
        foreach (cap[i]) begin
            n_cmp++;
            if (cap[i] !== exp_byte(i, 72)) begin n_bad++; $display("FAIL pause_byte[%0d] got %h want %h", i, cap[i], exp_byte(i, 72)); end
        end
    endtask

    task automatic test_lines_limit();
        logic [7:0] want [12] = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h0D, 8'h0A,
                                  8'h21, 8'h22, 8'h23, 8'h24, 8'h0D, 8'h0A};
        logic [7:0] cap[$];
        apply_reset();
        for (int c = 0; c < 40; c++) begin
            set_inputs(1'b0, 1'b1);
            if (cap.size() == 11 && n_wr_b === 1'b0) begin
                n_cmp++; if (n_done_b !== 1'b1) begin n_bad++; $display("FAIL lim_done_early got %b want 1", n_done_b); end
            end
            if (cap.size() >= 12) begin
                n_cmp++; if (n_wr_b !== 1'b1) begin n_bad++; $display("FAIL lim_extra_write[cycle %0d] got %b want 1", c, n_wr_b); end
                n_cmp++; if (n_done_b !== 1'b0) begin n_bad++; $display("FAIL lim_n_done[cycle %0d] got %b want 0", c, n_done_b); end
            end
            if (n_wr_b === 1'b0) cap.push_back(port_out_b);
        end
        n_cmp++; if (cap.size() != 12) begin n_bad++; $display("FAIL lim_count got %0d want 12", cap.size()); end
        for (int i = 0; i < 12 && i < cap.size(); i++) begin
            n_cmp++;
            if (cap[i] !== want[i]) begin n_bad++; $display("FAIL lim_byte[%0d] got %h want %h", i, cap[i], want[i]); end
        end
        n_cmp++; if (line_cnt_b !== 16'd2) begin n_bad++; $display("FAIL lim_line_cnt got %0d want 2", line_cnt_b); end
    endtask

    task automatic test_async_reset();
        int nw;
        logic [7:0] first[$];
        apply_reset();
        nw = 0;
        for (int c = 0; c < 400 && nw < 252; c++) begin
            set_inputs(1'b0, 1'b1);
            if (n_wr === 1'b0) nw++;
        end
        set_inputs(1'b0, 1'b1);
        n_cmp++; if (n_wr !== 1'b0 || port_out !== 8'h41) begin n_bad++; $display("FAIL ar_pre got n_wr=%b %h want 0 41", n_wr, port_out); end
        n_cmp++; if (line_cnt !== 16'd3) begin n_bad++; $display("FAIL ar_pre_line_cnt got %0d want 3", line_cnt); end
        rst = 1'b1;
        #1;
        n_cmp++; if (n_wr !== 1'b1)      begin n_bad++; $display("FAIL ar_n_wr got %b want 1", n_wr); end
        n_cmp++; if (port_out !== 8'h20) begin n_bad++; $display("FAIL ar_port_out got %h want 20", port_out); end
        n_cmp++; if (line_cnt !== 16'd0) begin n_bad++; $display("FAIL ar_line_cnt got %0d want 0", line_cnt); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 10 && first.size() < 2; c++) begin
            set_inputs(1'b0, 1'b1);
            if (n_wr === 1'b0) first.push_back(port_out);
        end
        n_cmp++;
        if (first.size() != 2) begin
            n_bad++; $display("FAIL ar_restart_count got %0d want 2", first.size());
        end else if (first[0] !== 8'h20 || first[1] !== 8'h21) begin
            n_bad++; $display("FAIL ar_restart got %h %h want 20 21", first[0], first[1]);
        end
    endtask

    initial begin
        test_reset();
        test_first_line();
        test_rotation();
        test_back_pressure();
        test_pause();
        test_lines_limit();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
